instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetch stage of the 5-stage RV32 pipeline, directly upstream of the IF/ID pipeline register. Owns the program counter, issues single-outstanding word fetches to instruction memory over a request/grant/response handshake, and buffers returned instructions in a small queue that absorbs downstream stalls. Presents the head entry as the instruction and PC+4 that the IF/ID register captures, and handles control-flow redirects, including discarding a response that is already in flight.

## Interface
- XLEN, 32, datapath and PC width
- RESET_PC, 32'h00000000, PC value loaded on reset
- NOP_INSTRUCTION, 32'h00000013, instruction driven while the queue is empty
- QUEUE_DEPTH, 2, instruction queue entries; power of two, ≥2
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- stall_i  input  1  downstream hold; the head entry is consumed at an edge where if_valid=1 and stall_i=0
- redirect_valid  input  1  branch/jump redirect request
- redirect_pc  input  XLEN  redirect target; bits [1:0] forced to 0
- imem_req  output  1  fetch request
- imem_addr  output  XLEN  fetch address, word aligned
- imem_gnt  input  1  memory accepts the request in the current cycle; ignored unless imem_req=1
- imem_rvalid  input  1  read data valid; no backpressure
- imem_rdata  input  XLEN  fetched instruction
- if_instruction  output  XLEN  head instruction, or NOP_INSTRUCTION when empty
- if_pc_plus_4  output  XLEN  head PC+4, or 0 when empty
- if_valid  output  1  queue non-empty

## Operation
- State machine with two states, FETCH_REQ and FETCH_WAIT, plus a drop flag, a pc register and a count register (0..QUEUE_DEPTH).
- imem_req = (state==FETCH_REQ) && (count < QUEUE_DEPTH) && !redirect_valid. This is combinational and uses count before any same-cycle dequeue. imem_addr = pc.
- FETCH_REQ: on imem_req && imem_gnt, latch fetch_pc <= pc, set pc <= pc+4, and go to FETCH_WAIT.
- FETCH_WAIT: imem_req=0. On imem_rvalid:
  - drop=1: discard the data, clear drop, go to FETCH_REQ.
  - drop=0 and no redirect: enqueue {imem_rdata, fetch_pc+4}, go to FETCH_REQ.
- Space for an enqueue is guaranteed because a request is issued only when count < QUEUE_DEPTH.
- Redirect (highest priority, any state):
  - Flush the queue (count <= 0) and set pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - In FETCH_WAIT without rvalid: set drop <= 1 and stay in FETCH_WAIT.
  - In FETCH_WAIT with rvalid in the same cycle: discard the data, clear drop, go to FETCH_REQ.
  - In FETCH_REQ: no request is made this cycle.
- Enqueue and dequeue in the same cycle leave count unchanged. Dequeue on an empty queue is a no-op.
- Arithmetic is modulo 2^XLEN: pc+4 from 0xFFFFFFFC wraps to 0.
- Outputs are driven combinationally from the queue head entry.

## Timing
- Reset values:
  - state=FETCH_REQ, pc=RESET_PC, count=0, drop=0.
  - if_valid=0, if_instruction=NOP_INSTRUCTION, if_pc_plus_4=0.
  - imem_req rises in the first cycle after rst deasserts.
- Fetch latency with grant in cycle 0 and rvalid in cycle 1: if_valid=1 after the edge ending cycle 1.
- Throughput with a single-cycle memory is one instruction every 2 cycles. Longer rvalid latency stretches FETCH_WAIT.
- The earliest rvalid is the cycle after the grant. rvalid outside FETCH_WAIT is ignored.
- Redirect takes effect at the next edge. The first request to the new pc is:
  - the following cycle, if the block was in FETCH_REQ, or
  - the cycle after the stale response arrives, if it was in FETCH_WAIT.
- rst asserted mid-transaction returns all state immediately; a late rvalid after reset is ignored because the block is in FETCH_REQ.

## Test plan
- Reset with RESET_PC=0x100 -> imem_req=0 and if_valid=0 during reset, if_instruction=0x00000013. First cycle after release: imem_req=1, imem_addr=0x100.
- 1-cycle memory returning 0xAAAA0001, 0xAAAA0002 with stall_i=0 -> if_pc_plus_4 shows 0x104 then 0x108, each entry valid for one cycle, one entry every 2 cycles.
- stall_i=1 held -> two entries queued, imem_req stays 0 while count=2. Release stall -> entries drain in order, then fetching resumes at 0x108.
- Redirect to 0x2002 while in FETCH_WAIT, rvalid 3 cycles later -> that response is dropped, the queue is empty, and the next imem_addr=0x2000.
- redirect_valid and imem_rvalid in the same cycle -> data not enqueued, count=0, next imem_addr = redirect target.
- Redirect to 0xFFFFFFFC -> entry has if_pc_plus_4=0x00000000, and the next imem_addr=0x00000000.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - RV32 fetch stage: PC, single-outstanding imem fetch, instruction queue, redirect
module instruction_fetch_unit #(
    parameter int              XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = 32'h00000000,
    parameter logic [XLEN-1:0] NOP_INSTRUCTION = 32'h00000013,
    parameter int              QUEUE_DEPTH     = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] if_instruction,
    output logic [XLEN-1:0] if_pc_plus_4,
    output logic            if_valid
);

    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    typedef enum logic {
        FETCH_REQ  = 1'b0,
        FETCH_WAIT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_fetch_pc;
    logic              r_drop;
    logic              w_drop_next;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [XLEN-1:0]   r_q_instr [QUEUE_DEPTH];
    logic [XLEN-1:0]   r_q_pcp4  [QUEUE_DEPTH];
    logic              w_req;
    logic              w_grant;
    logic              w_enq;
    logic              w_deq;
    logic              w_valid;
    logic [XLEN-1:0]   w_redirect_aligned;

    assign w_redirect_aligned = redirect_pc & ~XLEN'(3);
    assign w_valid            = (r_count != '0);
    assign w_deq              = w_valid && !stall_i;
    assign w_grant            = w_req && imem_gnt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FETCH_REQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, request and enqueue decisions; redirect suppresses both request and enqueue
    always_comb begin
        w_state_next = r_state;
        w_drop_next  = r_drop;
        w_enq        = 1'b0;
        w_req        = (r_state == FETCH_REQ) && (r_count < CNT_W'(QUEUE_DEPTH))
                       && !redirect_valid && !rst;
        case (r_state)
            FETCH_REQ: begin
                if (w_req && imem_gnt) begin
                    w_state_next = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid) begin
                    w_state_next = FETCH_REQ;
                    w_drop_next  = 1'b0;
                    w_enq        = !r_drop && !redirect_valid;
                end else if (redirect_valid) begin
                    w_drop_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = FETCH_REQ;
            end
        endcase
    end

    // PC, drop flag and queue occupancy; a redirect flushes the queue and reloads the PC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_fetch_pc <= RESET_PC;
            r_drop     <= 1'b0;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            r_drop <= w_drop_next;
            if (redirect_valid) begin
                r_pc    <= w_redirect_aligned;
                r_count <= '0;
                r_head  <= '0;
                r_tail  <= '0;
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_pc;
                    r_pc       <= r_pc + XLEN'(4);
                end
                if (w_enq) begin
                    r_tail <= r_tail + PTR_W'(1);
                end
                if (w_deq) begin
                    r_head <= r_head + PTR_W'(1);
                end
                case ({w_enq, w_deq})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Queue storage; the tail slot is always free when a response is accepted
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_instr[r_tail] <= imem_rdata;
            r_q_pcp4[r_tail]  <= r_fetch_pc + XLEN'(4);
        end
    end

    assign imem_req       = w_req;
    assign imem_addr      = r_pc;
    assign if_valid       = w_valid;
    assign if_instruction = w_valid ? r_q_instr[r_head] : NOP_INSTRUCTION;
    assign if_pc_plus_4   = w_valid ? r_q_pcp4[r_head] : '0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h00000100;
    localparam logic [31:0] NOP    = 32'h00000013;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] if_instruction;
    logic [31:0] if_pc_plus_4;
    logic        if_valid;

    instruction_fetch_unit #(
        .XLEN(32),
        .RESET_PC(RST_PC),
        .NOP_INSTRUCTION(NOP),
        .QUEUE_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall_i(stall_i),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .if_instruction(if_instruction),
        .if_pc_plus_4(if_pc_plus_4),
        .if_valid(if_valid)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcp4;
    } ent_t;

    // Reference model: instruction queue, next fetch address, one outstanding fetch
    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_fpc;
    bit          m_pend;
    bit          m_drop;
    logic [31:0] data_ctr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_q.delete();
        m_pc   = RST_PC;
        m_fpc  = RST_PC;
        m_pend = 1'b0;
        m_drop = 1'b0;
    endtask

    task automatic check_all();
        bit exp_req;
        exp_req = !rst && !m_pend && (m_q.size() < DEPTH) && !redirect_valid;
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        chk("imem_addr", imem_addr, m_pc);
        chk("if_valid", 32'(if_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("if_instruction", if_instruction, m_q[0].instr);
            chk("if_pc_plus_4", if_pc_plus_4, m_q[0].pcp4);
        end else begin
            chk("if_instruction_empty", if_instruction, NOP);
            chk("if_pc_plus_4_empty", if_pc_plus_4, 32'h0);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, check, advance the model, cross the rising edge
    task automatic step(input bit st, input bit rv, input logic [31:0] rpc,
                        input bit g, input bit rvl, input logic [31:0] rd);
        bit req;
        bit deq;
        stall_i        = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_gnt       = g;
        imem_rvalid    = rvl;
        imem_rdata     = rd;
        #1;
        check_all();
        req = !m_pend && (m_q.size() < DEPTH) && !rv;
        deq = (m_q.size() != 0) && !st;
        if (rv) begin
            m_q.delete();
            m_pc = {rpc[31:2], 2'b00};
            if (m_pend) begin
                if (rvl) begin
                    m_pend = 1'b0;
                    m_drop = 1'b0;
                end else begin
                    m_drop = 1'b1;
                end
            end
        end else begin
            if (deq) void'(m_q.pop_front());
            if (m_pend && rvl) begin
                if (!m_drop) m_q.push_back('{instr: rd, pcp4: m_fpc + 32'd4});
                m_drop = 1'b0;
                m_pend = 1'b0;
            end else if (req && g) begin
                m_fpc  = m_pc;
                m_pc   = m_pc + 32'd4;
                m_pend = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Single-cycle memory: always grants, answers the cycle after the grant with a counting pattern
    task automatic mem(input bit st);
        bit rvl;
        rvl = m_pend;
        if (rvl) data_ctr = data_ctr + 32'd1;
        step(st, 1'b0, 32'h0, 1'b1, rvl, data_ctr);
    endtask

    // Asserts reset between clock edges so the asynchronous clear is observed immediately
    task automatic do_reset();
        stall_i        = 1'b0;
        redirect_valid = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        #2 rst = 1'b1;
        #1;
        m_reset();
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'h0);
        chk("rst_if_instruction", if_instruction, NOP);
        chk("rst_if_pc_plus_4", if_pc_plus_4, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_imem_req", 32'(imem_req), 32'h0);
        chk("rst_hold_imem_addr", imem_addr, RST_PC);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        stall_i        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        data_ctr       = 32'hAAAA0000;
        @(negedge clk);

        // reset values and first request
        do_reset();
        chk("first_req", 32'(imem_req), 32'h1);
        chk("first_addr", imem_addr, 32'h00000100);

        // single-cycle memory, no stall: one entry every 2 cycles
        mem(1'b0);
        mem(1'b0);
        chk("stream0_valid", 32'(if_valid), 32'h1);
        chk("stream0_pcp4", if_pc_plus_4, 32'h00000104);
        chk("stream0_instr", if_instruction, 32'hAAAA0001);
        mem(1'b0);
        chk("stream_gap_valid", 32'(if_valid), 32'h0);
        mem(1'b0);
        chk("stream1_pcp4", if_pc_plus_4, 32'h00000108);
        chk("stream1_instr", if_instruction, 32'hAAAA0002);
        mem(1'b0);
        chk("stream_end_valid", 32'(if_valid), 32'h0);
        chk("stream_end_addr", imem_addr, 32'h0000010C);

        // stall fills the queue, request held off while full, then drain in order
        do_reset();
        data_ctr = 32'hAAAA0000;
        repeat (4) mem(1'b1);
        chk("full_pcp4", if_pc_plus_4, 32'h00000104);
        chk("full_req", 32'(imem_req), 32'h0);
        mem(1'b1);
        chk("full_req_hold", 32'(imem_req), 32'h0);
        chk("full_head_hold", if_pc_plus_4, 32'h00000104);
        mem(1'b0);
        chk("drain_pcp4", if_pc_plus_4, 32'h00000108);
        chk("drain_instr", if_instruction, 32'hAAAA0002);
        chk("drain_addr", imem_addr, 32'h00000108);
        mem(1'b0);
        chk("drain_empty", 32'(if_valid), 32'h0);
        chk("resume_addr", imem_addr, 32'h0000010C);

        // redirect while waiting: stale response arrives later and is dropped
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h00002002, 1'b0, 1'b0, 32'h0);
        chk("drop_addr", imem_addr, 32'h00002000);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("drop_wait_req", 32'(imem_req), 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD0001);
        chk("drop_empty", 32'(if_valid), 32'h0);
        chk("drop_req", 32'(imem_req), 32'h1);
        chk("drop_next_addr", imem_addr, 32'h00002000);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h12345678);
        chk("after_drop_pcp4", if_pc_plus_4, 32'h00002004);
        chk("after_drop_instr", if_instruction, 32'h12345678);

        // redirect and rvalid in the same cycle, with a queued entry to flush
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h00003000, 1'b0, 1'b1, 32'hBEEF0000);
        chk("same_cycle_empty", 32'(if_valid), 32'h0);
        chk("same_cycle_addr", imem_addr, 32'h00003000);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("same_cycle_grant_addr", imem_addr, 32'h00003004);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h33330000);

        // redirect to the top word, misaligned target, PC wraps to zero
        step(1'b0, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0, 32'h0);
        chk("wrap_addr", imem_addr, 32'hFFFFFFFC);
        chk("wrap_flush", 32'(if_valid), 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("wrap_next_addr", imem_addr, 32'h00000000);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFE0000);
        chk("wrap_pcp4", if_pc_plus_4, 32'h00000000);
        chk("wrap_instr", if_instruction, 32'hCAFE0000);

        // reset mid-transaction, late rvalid afterwards is ignored
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0BAD0BAD);
        chk("late_rvalid_empty", 32'(if_valid), 32'h0);
        chk("late_rvalid_addr", imem_addr, 32'h00000100);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit          st;
            bit          rv;
            bit          g;
            bit          rvl;
            logic [31:0] rpc;
            st  = ($urandom_range(0, 2) == 0);
            rv  = ($urandom_range(0, 15) == 0);
            rpc = $urandom();
            g   = ($urandom_range(0, 3) != 0);
            rvl = m_pend ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step(st, rv, rpc, g, rvl, $urandom());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
